// File: rtl/nes_pkg.sv
// Shared types and constants for the NES gamepad poll controller.
package nes_pkg;

    // State encodings kept as plain constants so older code can keep matching on them.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CLK_HI = 3'd3;
    localparam logic [2:0] ST_CLK_LO = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LATCH  = ST_LATCH,
        WAIT   = ST_WAIT,
        CLK_HI = ST_CLK_HI,
        CLK_LO = ST_CLK_LO,
        DONE   = ST_DONE
    } nes_state_t;

    // Bit positions in the published button byte (serial order from the pad).
    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    localparam logic [4:0] FRAME_TICKS = 5'd17;
    localparam logic [1:0] LATCH_TICKS = 2'd2;

    // The bit index register doubles as the latch tick counter; this is its last value.
    localparam logic [2:0] LATCH_LAST_IDX = 3'(LATCH_TICKS) - 3'd1;

endpackage

// File: rtl/nes_tick_timer.sv
// Modulo-DIV counter with synchronous clear; tick_end flags the last count.
module nes_tick_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_end
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count_r;

    assign tick_end = (count_r == LAST);

    // Count 0..DIV-1, restarting on clear or after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear || tick_end) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + W'(1);
        end
    end

endmodule

// File: rtl/nes_poll_controller.sv
// Sequences one NES pad read (latch pulse + 8 serial bits) and publishes the
// active-high button byte with a one-cycle valid strobe.
module nes_poll_controller
    import nes_pkg::*;
#(
    parameter int TICK_DIV = 300,
    parameter int POLL_DIV = 833_333
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       start,
    input  logic       D,
    output logic       SRL,
    output logic       SRCLK,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);
    nes_state_t state_r, next_state_s;
    logic [2:0] bit_idx_r;
    logic [7:0] stage_r;
    logic       d_meta_r, d_sync_r;
    logic       pending_r;
    logic       tick_end_s, poll_wrap_s, tick_clear_s, poll_clear_s, trigger_s;
    logic       srl_r, srclk_r, valid_r, busy_r;
    logic [7:0] buttons_r;

    // The tick timer restarts whenever the FSM changes state; the poll timer is parked while disabled.
    assign tick_clear_s = (next_state_s != state_r);
    assign poll_clear_s = ~en;
    assign trigger_s    = en & (start | poll_wrap_s);

    nes_tick_timer #(.DIV(TICK_DIV)) u_tick_timer (
        .clk      (CLK),
        .rst_n    (reset),
        .clear    (tick_clear_s),
        .tick_end (tick_end_s)
    );

    nes_tick_timer #(.DIV(POLL_DIV)) u_poll_timer (
        .clk      (CLK),
        .rst_n    (reset),
        .clear    (poll_clear_s),
        .tick_end (poll_wrap_s)
    );

    // Two-flop synchronizer for the asynchronous pad data line (idles high = released).
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            d_meta_r <= 1'b1;
            d_sync_r <= 1'b1;
        end else begin
            d_meta_r <= D;
            d_sync_r <= d_meta_r;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en && (trigger_s || pending_r)) next_state_s = LATCH;
                else                                 next_state_s = IDLE;
            end
            LATCH: begin
                if (tick_end_s && (bit_idx_r == LATCH_LAST_IDX)) next_state_s = WAIT;
                else                                             next_state_s = LATCH;
            end
            WAIT: begin
                if (tick_end_s) next_state_s = CLK_HI;
                else            next_state_s = WAIT;
            end
            CLK_HI: begin
                if (tick_end_s) next_state_s = CLK_LO;
                else            next_state_s = CLK_HI;
            end
            CLK_LO: begin
                if (tick_end_s && (bit_idx_r == BTN_RIGHT)) next_state_s = DONE;
                else if (tick_end_s)                        next_state_s = CLK_HI;
                else                                        next_state_s = CLK_LO;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // One-deep request memory for triggers that arrive mid-frame; consumed when IDLE starts a frame.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                 pending_r <= 1'b0;
        else if (!en)               pending_r <= 1'b0;
        else if (state_r == IDLE)   pending_r <= 1'b0;
        else if (trigger_s)         pending_r <= 1'b1;
        else                        pending_r <= pending_r;
    end

    // Bit index (also counts latch ticks) and the staging register for sampled bits.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bit_idx_r <= 3'd0;
            stage_r   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: bit_idx_r <= 3'd0;
                LATCH: begin
                    if (tick_end_s) begin
                        bit_idx_r <= (bit_idx_r == LATCH_LAST_IDX) ? 3'd0 : bit_idx_r + 3'd1;
                    end
                end
                WAIT: begin
                    if (tick_end_s) begin
                        stage_r[BTN_A] <= ~d_sync_r;
                        bit_idx_r      <= 3'd1;
                    end
                end
                CLK_LO: begin
                    if (tick_end_s) begin
                        stage_r[bit_idx_r] <= ~d_sync_r;
                        if (bit_idx_r != BTN_RIGHT) bit_idx_r <= bit_idx_r + 3'd1;
                    end
                end
                default: bit_idx_r <= bit_idx_r;
            endcase
        end
    end

    // Registered pad controls and status; buttons only move when a whole frame is done.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            srl_r     <= 1'b0;
            srclk_r   <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            buttons_r <= 8'h00;
        end else begin
            srl_r   <= (state_r == LATCH);
            srclk_r <= (state_r == CLK_HI);
            valid_r <= (state_r == DONE);
            busy_r  <= (state_r != IDLE);
            if (state_r == DONE) buttons_r <= stage_r;
        end
    end

    assign SRL     = srl_r;
    assign SRCLK   = srclk_r;
    assign valid   = valid_r;
    assign busy    = busy_r;
    assign buttons = buttons_r;

endmodule

// File: tb/tb_nes_poll_controller.sv
// Scoreboard bench for nes_poll_controller with a behavioural 4021-style pad.
module tb_nes_poll_controller;
    localparam int TD = 4;
    localparam int PD = 200;

    logic       CLK = 1'b0;
    logic       reset, en, start, D;
    logic       SRL, SRCLK, valid, busy;
    logic [7:0] buttons;

    nes_poll_controller #(.TICK_DIV(TD), .POLL_DIV(PD)) dut (
        .CLK(CLK), .reset(reset), .en(en), .start(start), .D(D),
        .SRL(SRL), .SRCLK(SRCLK), .buttons(buttons), .valid(valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // cyc equals k after rising edge k
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pad model: parallel load while SRL high, shift on SRCLK rise; data is active low.
    logic [7:0] pad_mask;
    logic [7:0] pad_sr  = 8'hFF;
    logic       srclk_q = 1'b0;
    logic       use_pad, d_man;
    always @(posedge CLK) begin
        srclk_q <= SRCLK;
        if (SRL) pad_sr <= ~pad_mask;
        else if (SRCLK && !srclk_q) pad_sr <= {1'b1, pad_sr[7:1]};
    end
    assign D = use_pad ? pad_sr[0] : d_man;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    typedef struct { logic [7:0] btn; int at; } exp_t;
    exp_t sb[$];

    // Monitor: every valid pops one expected frame and checks its byte and arrival cycle.
    always @(negedge CLK) begin
        if (valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with buttons 0x%0h at cycle %0d, expected none",
                         buttons, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_buttons", int'(buttons), int'(e.btn));
                check("valid_cycle", cyc, e.at);
            end
        end
    end

    int w_srl_rise, w_srl_hi, w_ck_rise, w_ck_bad, w_busy_rise, w_busy_fall;

    // Observe pad signals for ncyc cycles, recording edges and SRCLK pulse widths.
    task automatic watch(input int ncyc);
        logic p_srl, p_ck, p_busy;
        int hi_run, lo_run;
        p_srl = SRL; p_ck = SRCLK; p_busy = busy;
        w_srl_rise = -1; w_srl_hi = 0; w_ck_rise = 0; w_ck_bad = 0;
        w_busy_rise = -1; w_busy_fall = -1; hi_run = 0; lo_run = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            if (SRL && !p_srl && w_srl_rise < 0) w_srl_rise = cyc;
            if (SRL) w_srl_hi++;
            if (SRCLK) begin
                if (!p_ck) begin
                    w_ck_rise++;
                    if (w_ck_rise > 1 && lo_run != TD) w_ck_bad++;
                    hi_run = 1;
                end else hi_run++;
            end else begin
                if (p_ck) begin
                    if (hi_run != TD) w_ck_bad++;
                    lo_run = 1;
                end else lo_run++;
            end
            if (busy && !p_busy && w_busy_rise < 0) w_busy_rise = cyc;
            if (!busy && p_busy && w_busy_fall < 0) w_busy_fall = cyc;
            p_srl = SRL; p_ck = SRCLK; p_busy = busy;
        end
    endtask

    // Park the poll timer at 0, then enable; e is the first edge that sees en = 1.
    task automatic enable_fresh(output int e);
        en = 1'b0;
        @(negedge CLK);
        en = 1'b1;
        e = cyc + 1;
    endtask

    // One-cycle start pulse; t is the edge that samples it.
    task automatic pulse_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    int e, t, t2, t3;

    initial begin
        reset = 1'b0; en = 1'b0; start = 1'b0; use_pad = 1'b1; d_man = 1'b1; pad_mask = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset_srl", SRL, 0);
        check("reset_srclk", SRCLK, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_buttons", int'(buttons), 0);
        reset = 1'b1;
        repeat (2) @(negedge CLK);

        // Single start: A and Right pressed
        pad_mask = 8'h81;
        enable_fresh(e);
        pulse_start(t);
        sb.push_back('{btn: 8'h81, at: t + 17*TD + 1});
        watch(80);
        check("single_srl_rise", w_srl_rise, t + 1);
        check("single_srl_width", w_srl_hi, 2*TD);
        check("single_srclk_pulses", w_ck_rise, 7);
        check("single_srclk_width_errs", w_ck_bad, 0);
        check("single_busy_rise", w_busy_rise, t + 1);
        check("single_busy_fall", w_busy_fall, t + 17*TD + 2);
        en = 1'b0;
        repeat (3) @(negedge CLK);

        // Data toggle: D flips one full cycle ahead of each sample edge
        use_pad = 1'b0; d_man = 1'b0;
        enable_fresh(e);
        pulse_start(t);
        sb.push_back('{btn: 8'h55, at: t + 69});
        while (cyc < t + 76) begin
            if (cyc >= t + 10 && cyc <= t + 66 && ((cyc - t - 10) % 8) == 0) d_man = ~d_man;
            @(negedge CLK);
        end
        en = 1'b0; use_pad = 1'b1;
        repeat (3) @(negedge CLK);

        // Start while busy: second start pends, third is dropped
        pad_mask = 8'h3C;
        enable_fresh(e);
        pulse_start(t);
        sb.push_back('{btn: 8'h3C, at: t + 69});
        wait_until(t + 19);
        pulse_start(t2);
        sb.push_back('{btn: 8'h3C, at: t + 70 + 69});
        wait_until(t + 39);
        pulse_start(t3);
        wait_until(t + 64);
        watch(20);
        check("pending_srl_rise", w_srl_rise, t + 71);
        wait_until(t + 150);
        check("pending_idle_after", busy, 0);
        en = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset mid-frame: everything drops at once, aborted frame never reports
        pad_mask = 8'hA5;
        enable_fresh(e);
        pulse_start(t);
        wait_until(t + 30);
        check("midreset_pre_srclk", SRCLK, 1);
        check("midreset_pre_busy", busy, 1);
        check("midreset_pre_buttons", int'(buttons), 8'h3C);
        en = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_srl", SRL, 0);
        check("midreset_srclk", SRCLK, 0);
        check("midreset_busy", busy, 0);
        check("midreset_valid", valid, 0);
        check("midreset_buttons", int'(buttons), 0);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        repeat (100) @(negedge CLK);
        check("midreset_after_busy", busy, 0);

        // en = 0 mid-frame: frame still completes; starts and polls are then ignored
        pad_mask = 8'h12;
        enable_fresh(e);
        pulse_start(t);
        sb.push_back('{btn: 8'h12, at: t + 69});
        wait_until(t + 30);
        en = 1'b0;
        wait_until(t + 100);
        pulse_start(t2);
        repeat (2) @(negedge CLK);
        check("disabled_start_ignored", busy, 0);
        wait_until(t + 400);

        // Auto poll after re-enable: poll timer restarts from 0
        pad_mask = 8'h00;
        en = 1'b1;
        e = cyc + 1;
        sb.push_back('{btn: 8'h00, at: e + PD - 1 + 69});
        sb.push_back('{btn: 8'h00, at: e + 2*PD - 1 + 69});
        sb.push_back('{btn: 8'h00, at: e + 3*PD - 1 + 69});
        wait_until(e + 190);
        watch(20);
        check("autopoll_srl_rise", w_srl_rise, e + PD);
        wait_until(e + 700);
        en = 1'b0;
        wait_until(e + 820);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
